// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, requester ids,
// debug snapshot and wait-counter sizing helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CORE = 1'b0;
  localparam req_id_t REQ_DMA  = 1'b1;

  typedef struct packed {
    arb_state_t state;
    req_id_t    winner;
    req_id_t    last_grant;
  } arb_dbg_t;

  // Counter holds values 0..latency-1; a latency of 1 still needs one bit.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  // Handshake: a requester raises *_req with a stable payload and holds both
  // until it samples *_ack high (a one-cycle pulse); on the following edge it
  // may drop *_req or present a new payload. rdata is valid from the ack cycle.
  logic                  core_req;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  core_ack;
  logic                  core_stall;

  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_ack;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_rdata, core_ack, core_stall,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_rdata, core_ack, core_stall,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter timing the ACCESS phase; loads MEM_LATENCY-1 and flags zero.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CW = cnt_width(MEM_LATENCY);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single memory port (IDLE/ACCESS/DONE).
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; default is core priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output arb_dbg_t             dbg_o
);

  arb_state_t            state_q;
  req_id_t               winner_q;
  req_id_t               last_grant_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  core_ack_q;
  logic                  dma_ack_q;
  logic [DATA_WIDTH-1:0] core_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;

  logic                  any_req;
  req_id_t               grant_d;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  cnt_zero;

  assign any_req = bus.core_req | bus.dma_req;

  always_comb begin
    grant_d = REQ_CORE;
    if (bus.core_req && bus.dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = (last_grant_q == REQ_CORE) ? REQ_DMA : REQ_CORE;
`else
      grant_d = REQ_CORE;
`endif
    end else if (bus.dma_req) begin
      grant_d = REQ_DMA;
    end
  end

  assign sel_we    = (grant_d == REQ_DMA) ? bus.dma_we    : bus.core_we;
  assign sel_addr  = (grant_d == REQ_DMA) ? bus.dma_addr  : bus.core_addr;
  assign sel_wdata = (grant_d == REQ_DMA) ? bus.dma_wdata : bus.core_wdata;

  arb_wait_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == IDLE && any_req),
    .dec_i  (state_q == ACCESS),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= REQ_CORE;
      last_grant_q <= REQ_DMA;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_ack_q   <= 1'b0;
      dma_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= ACCESS;
            winner_q    <= grant_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            state_q  <= DONE;
            mem_en_q <= 1'b0;
            // Only reads touch the winner's rdata; the loser's value is never disturbed.
            if (!mem_we_q) begin
              if (winner_q == REQ_CORE) core_rdata_q <= bus.mem_rdata;
              else                      dma_rdata_q  <= bus.mem_rdata;
            end
            if (winner_q == REQ_CORE) core_ack_q <= 1'b1;
            else                      dma_ack_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          core_ack_q   <= 1'b0;
          dma_ack_q    <= 1'b0;
          last_grant_q <= winner_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.core_ack   = core_ack_q;
  assign bus.dma_ack    = dma_ack_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.core_stall = bus.core_req & ~core_ack_q;

  assign dbg_o.state      = state_q;
  assign dbg_o.winner     = winner_q;
  assign dbg_o.last_grant = last_grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: latency-2 and latency-1 instances,
// vector table, contention sequence (both arbitration modes) and mid-access reset.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;
  arb_dbg_t dbg0;
  arb_dbg_t dbg1;

  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus0),
    .dbg_o (dbg0)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus1),
    .dbg_o (dbg1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] core_exp;
  logic [31:0] dma_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    req_id_t     who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus0.core_req = 1'b0; bus0.core_we = 1'b0; bus0.core_addr = '0; bus0.core_wdata = '0;
    bus0.dma_req  = 1'b0; bus0.dma_we  = 1'b0; bus0.dma_addr  = '0; bus0.dma_wdata  = '0;
    bus0.mem_rdata = '0;
    bus1.core_req = 1'b0; bus1.core_we = 1'b0; bus1.core_addr = '0; bus1.core_wdata = '0;
    bus1.dma_req  = 1'b0; bus1.dma_we  = 1'b0; bus1.dma_addr  = '0; bus1.dma_wdata  = '0;
    bus1.mem_rdata = '0;
  endtask

  // One transaction on the latency-2 instance; cycle 0 is the IDLE cycle seeing req.
  task automatic run_vec(input vec_t v);
    logic [31:0] got;
    logic [31:0] other;
    bus0.mem_rdata = v.mdata;
    if (v.who == REQ_CORE) begin
      bus0.core_req = 1'b1; bus0.core_we = v.we; bus0.core_addr = v.addr; bus0.core_wdata = v.wdata;
    end else begin
      bus0.dma_req = 1'b1; bus0.dma_we = v.we; bus0.dma_addr = v.addr; bus0.dma_wdata = v.wdata;
    end
    exp_q.push_back(v.exp_rdata);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) begin
        check("mem_en", 32'(bus0.mem_en), 32'd1);
        check("mem_we", 32'(bus0.mem_we), 32'(v.we));
        check("mem_addr", bus0.mem_addr, v.addr);
        if (v.we) check("mem_wdata", bus0.mem_wdata, v.wdata);
        check("state_access", 32'(dbg0.state), 32'(ACCESS));
      end else begin
        check("mem_en_off", 32'(bus0.mem_en), 32'd0);
      end
      check("core_ack", 32'(bus0.core_ack), 32'(k == 3 && v.who == REQ_CORE));
      check("dma_ack", 32'(bus0.dma_ack), 32'(k == 3 && v.who == REQ_DMA));
      check("core_stall", 32'(bus0.core_stall), 32'(k != 3 && v.who == REQ_CORE));
    end
    got   = (v.who == REQ_CORE) ? bus0.core_rdata : bus0.dma_rdata;
    other = (v.who == REQ_CORE) ? bus0.dma_rdata  : bus0.core_rdata;
    check("rdata", got, exp_q.pop_front());
    check("loser_rdata", other, (v.who == REQ_CORE) ? dma_exp : core_exp);
    if (v.who == REQ_CORE) core_exp = v.exp_rdata;
    else                   dma_exp  = v.exp_rdata;
    @(posedge clk);
    #1;
    bus0.core_req = 1'b0;
    bus0.dma_req  = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] r0;
    logic [31:0] r1;
    logic        exp_c;
    logic        exp_d;
    logic        rr_mode;
    int          n;

`ifdef ARB_ROUND_ROBIN_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    r0 = $urandom;
    r1 = $urandom;
    vecs[0] = '{REQ_CORE, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{REQ_DMA,  1'b1, 32'h0000_0040, 32'h1234_5678, 32'hAAAA_5555, 32'h0};
    vecs[2] = '{REQ_DMA,  1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[3] = '{REQ_CORE, 1'b1, 32'h0000_0080, 32'h0000_0055, 32'h1111_1111, 32'hDEAD_BEEF};
    vecs[4] = '{REQ_DMA,  1'b1, 32'h0000_0048, r1,            32'h2222_2222, 32'hCAFE_F00D};
    vecs[5] = '{REQ_CORE, 1'b0, 32'h0000_0014, 32'h0,         r0,            r0};

    idle_inputs();
    core_exp = '0;
    dma_exp  = '0;
    do_reset();

    // Reset values
    @(negedge clk);
    check("rst_state", 32'(dbg0.state), 32'(IDLE));
    check("rst_last_grant", 32'(dbg0.last_grant), 32'(REQ_DMA));
    check("rst_mem_en", 32'(bus0.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus0.mem_we), 32'd0);
    check("rst_mem_addr", bus0.mem_addr, 32'd0);
    check("rst_mem_wdata", bus0.mem_wdata, 32'd0);
    check("rst_acks", 32'({bus0.core_ack, bus0.dma_ack}), 32'd0);
    check("rst_core_rdata", bus0.core_rdata, 32'd0);
    check("rst_dma_rdata", bus0.dma_rdata, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Contention: both request continuously from a fresh reset
    do_reset();
    bus0.mem_rdata = 32'h5A5A_0000;
    bus0.core_req = 1'b1; bus0.core_we = 1'b0; bus0.core_addr = 32'h100;
    bus0.dma_req  = 1'b1; bus0.dma_we  = 1'b0; bus0.dma_addr  = 32'h200;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      n = k / 4;
      exp_c = (k % 4 == 3) && (!rr_mode || (n % 2 == 0));
      exp_d = (k % 4 == 3) && rr_mode && (n % 2 == 1);
      check("arb_core_ack", 32'(bus0.core_ack), 32'(exp_c));
      check("arb_dma_ack", 32'(bus0.dma_ack), 32'(exp_d));
      check("arb_core_stall", 32'(bus0.core_stall), 32'(!exp_c));
      if (k % 4 == 1 || k % 4 == 2)
        check("arb_mem_addr", bus0.mem_addr, (rr_mode && (n % 2 == 1)) ? 32'h200 : 32'h100);
    end
    check("arb_core_rdata", bus0.core_rdata, 32'h5A5A_0000);
    check("arb_dma_rdata", bus0.dma_rdata, rr_mode ? 32'h5A5A_0000 : 32'h0);
    @(posedge clk);
    #1;
    bus0.core_req = 1'b0;
    bus0.dma_req  = 1'b0;

    // Reset during ACCESS of a core read, then reissue
    do_reset();
    bus0.mem_rdata = 32'h0BAD_F00D;
    bus0.core_req = 1'b1; bus0.core_we = 1'b0; bus0.core_addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    check("mid_mem_en", 32'(bus0.mem_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_state", 32'(dbg0.state), 32'(IDLE));
    check("mid_mem_en_off", 32'(bus0.mem_en), 32'd0);
    check("mid_no_ack", 32'(bus0.core_ack), 32'd0);
    check("mid_stall", 32'(bus0.core_stall), 32'd1);
    rst = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      check("re_mem_en", 32'(bus0.mem_en), 32'(k < 5));
      check("re_core_ack", 32'(bus0.core_ack), 32'(k == 5));
      check("re_stall", 32'(bus0.core_stall), 32'(k != 5));
    end
    check("re_rdata", bus0.core_rdata, 32'h0BAD_F00D);
    @(posedge clk);
    #1;
    bus0.core_req = 1'b0;

    // MEM_LATENCY = 1 instance: ack at cycle 2
    bus1.mem_rdata = 32'h1357_9BDF;
    bus1.core_req = 1'b1; bus1.core_we = 1'b0; bus1.core_addr = 32'h30;
    exp_q.push_back(32'h1357_9BDF);
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      check("l1_mem_en", 32'(bus1.mem_en), 32'(k == 1));
      check("l1_core_ack", 32'(bus1.core_ack), 32'(k == 2));
      check("l1_dma_ack", 32'(bus1.dma_ack), 32'd0);
    end
    check("l1_rdata", bus1.core_rdata, exp_q.pop_front());
    @(posedge clk);
    #1;
    bus1.core_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
